stage_mem: RTL and testbench

Memory-access stage of the 5-stage core, directly downstream of the execute stage. Consumes the EX/MEM-registered ALU result (address) and forwarded store data, runs a request/ready transaction on the data-memory port, and produces the aligned, sign/zero-extended load result for write-back. Stalls the pipeline while a transaction is outstanding. Flags misaligned accesses and bus timeouts.

---
 rtl/stage_mem_pkg.sv | 33 +++
 rtl/stage_mem_align.sv | 62 ++++++
 rtl/stage_mem.sv | 127 ++++++++++++
 tb/tb_stage_mem.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the MEM stage: load/store size codes, FSM states
// and the size decode used by both the stage controller and the lane logic.
package stage_mem_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_e;

  // Stores reuse the load codes for size; unused codes 3/6/7 act as word.
  function automatic mem_size_e decode_size(input logic [2:0] func3);
    case (func3)
      LB, LBU: return SIZE_B;
      LH, LHU: return SIZE_H;
      LW:      return SIZE_W;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_align.sv
// Combinational byte-lane logic: store enables/replication, misalignment
// detection and load extraction with sign/zero extension.
module stage_mem_align
  import stage_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  mem_size_e   size;
  logic        sign_ext;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size     = decode_size(func3);
  assign sign_ext = ~func3[2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = load_word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_lo];
  assign half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    be         = 4'hF;
    wdata      = store_data;
    misaligned = 1'b0;
    case (size)
      SIZE_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: misaligned = |addr_lo;
    endcase
  end

  always_comb begin
    load_data = load_word;
    case (size)
      SIZE_B:  load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM stage: runs one request/ready data-memory transaction per load/store,
// stalling the pipeline until the result is ready for write-back.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        me_valid,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [2:0]  me_func3_code,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] me_result_o,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];

  mem_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rdata_reg;
  logic [2:0]        func3_reg;
  logic [1:0]        addr_lo_reg;
  logic              load_reg;

  logic              access;
  logic              start;
  logic              in_idle;
  logic [2:0]        align_func3;
  logic [1:0]        align_addr_lo;
  logic [3:0]        align_be;
  logic [31:0]       align_wdata;
  logic              align_mis;
  logic [31:0]       load_data;

  assign in_idle = (state == MEM_IDLE);
  assign access  = me_valid & (me_mem_read | me_mem_write);

  // Lane logic sees the live instruction in IDLE and the captured one in DONE.
  assign align_func3   = in_idle ? me_func3_code  : func3_reg;
  assign align_addr_lo = in_idle ? me_alu_o[1:0]  : addr_lo_reg;

  stage_mem_align u_align (
    .func3      (align_func3),
    .addr_lo    (align_addr_lo),
    .store_data (me_regs_data2),
    .load_word  (rdata_reg),
    .be         (align_be),
    .wdata      (align_wdata),
    .misaligned (align_mis),
    .load_data  (load_data)
  );

  assign start       = in_idle & access & ~align_mis;
  assign misalign    = rstn & in_idle & access & align_mis;
  assign mem_stall   = rstn & (start | (state == MEM_REQ));
  assign me_result_o = ((state == MEM_DONE) && load_reg) ? load_data : me_alu_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= MEM_IDLE;
      cnt         <= '0;
      rdata_reg   <= '0;
      func3_reg   <= '0;
      addr_lo_reg <= '0;
      load_reg    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (start) begin
            dmem_req    <= 1'b1;
            dmem_we     <= me_mem_write;
            dmem_addr   <= {me_alu_o[31:2], 2'b00};
            dmem_be     <= align_be;
            dmem_wdata  <= align_wdata;
            func3_reg   <= me_func3_code;
            addr_lo_reg <= me_alu_o[1:0];
            load_reg    <= ~me_mem_write;
            cnt         <= '0;
            state       <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (dmem_ready) begin
            dmem_req  <= 1'b0;
            rdata_reg <= dmem_rdata;
            state     <= MEM_DONE;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            dmem_req  <= 1'b0;
            rdata_reg <= '0;
            bus_err   <= 1'b1;
            state     <= MEM_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEM_DONE: begin
          // The pipeline advances on this edge, so never re-issue here.
          bus_err <= 1'b0;
          state   <= MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized scoreboard bench for stage_mem against a byte-array memory model.
module tb_stage_mem;

  localparam int TIMEOUT = 4;
  localparam int NEVER   = 99;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        me_valid, me_mem_read, me_mem_write;
  logic [2:0]  me_func3_code;
  logic [31:0] me_alu_o, me_regs_data2;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] me_result_o;
  logic        misalign, bus_err;

  always #5 clk = ~clk;

  stage_mem #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .me_valid(me_valid), .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_func3_code(me_func3_code), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .me_result_o(me_result_o),
    .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    string       name;
    logic [31:0] result;
    bit          mis;
    bit          err;
    int          stalls;
  } res_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wait_n;
  } bus_t;

  res_t        res_q[$];
  bus_t        bus_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          aborted = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: one completion whenever a valid instruction is not stalled.
  initial begin
    int   stall_cnt;
    res_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_cnt = 0;
      end else if (me_valid) begin
        if (mem_stall) begin
          stall_cnt++;
        end else begin
          if (res_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_completion: got result 0x%08h, expected none", me_result_o);
          end else begin
            e = res_q.pop_front();
            check({e.name, " result"}, me_result_o, e.result);
            check({e.name, " misalign"}, 32'(misalign), 32'(e.mis));
            check({e.name, " bus_err"}, 32'(bus_err), 32'(e.err));
            check({e.name, " stall_cycles"}, 32'(stall_cnt), 32'(e.stalls));
            $display("txn %-12s result=0x%08h misalign=%0b bus_err=%0b stalls=%0d",
                     e.name, me_result_o, misalign, bus_err, stall_cnt);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Slave: checks each request against the expected bus access, answers after wait_n cycles.
  initial begin
    bit          active;
    int          k;
    bus_t        b;
    logic [68:0] snap;
    int          idx;
    active     = 1'b0;
    k          = 0;
    b          = '{we: 1'b0, addr: '0, be: '0, wdata: '0, wait_n: 0};
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      if (!dmem_req) begin
        if (active && !aborted) begin
          check("timeout_req_cycles", 32'(k + 1), 32'(TIMEOUT));
          check("timeout_expected", 32'(b.wait_n), 32'(NEVER));
        end
        active = 1'b0;
      end else begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_request: got addr 0x%08h, expected no request", dmem_addr);
            b = '{we: dmem_we, addr: dmem_addr, be: dmem_be, wdata: dmem_wdata, wait_n: 0};
          end else begin
            b = bus_q.pop_front();
            check("req_we", 32'(dmem_we), 32'(b.we));
            check("req_addr", dmem_addr, b.addr);
            check("req_be", 32'(dmem_be), 32'(b.be));
            if (b.we) check("req_wdata", dmem_wdata, b.wdata);
          end
          active = 1'b1;
          k      = 0;
          snap   = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
        end else begin
          k++;
          n_cmp++;
          if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== snap) begin
            n_err++;
            $display("FAIL req_stable: got addr 0x%08h be %h, expected addr 0x%08h be %h",
                     dmem_addr, dmem_be, snap[67:36], snap[35:32]);
          end
        end
        if (k == b.wait_n) begin
          dmem_ready = 1'b1;
          idx        = int'(dmem_addr[9:2]);
          if (dmem_we) begin
            for (int i = 0; i < 4; i++)
              if (dmem_be[i]) slave_mem[idx][8*i +: 8] = dmem_wdata[8*i +: 8];
          end else begin
            dmem_rdata = slave_mem[idx];
          end
          active = 1'b0;
        end
      end
    end
  end

  task automatic wait_advance();
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      c++;
      if (c > 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL stall_bound: got stall for %0d cycles, expected at most 40", c);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: sizes as byte counts, memory as a word array edited byte by byte.
  task automatic issue(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int w,
                       input string name);
    int          n, off, idx;
    bit          acc;
    res_t        e;
    bus_t        b;
    logic [31:0] word, val;
    acc = v && (rd || wr);
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    idx = int'(a[9:2]);
    e.name   = name;
    e.mis    = acc && ((n == 4 && off != 0) || (n == 2 && (off % 2) != 0));
    e.err    = 1'b0;
    e.stalls = 0;
    e.result = a;
    if (acc && !e.mis) begin
      e.err    = (w >= NEVER);
      e.stalls = e.err ? 1 + TIMEOUT : w + 2;
      b.we     = wr;
      b.addr   = {a[31:2], 2'b00};
      b.be     = 4'(((1 << n) - 1) << off);
      b.wdata  = (n == 4) ? d : (n == 2) ? {2{d[15:0]}} : {4{d[7:0]}};
      b.wait_n = w;
      bus_q.push_back(b);
      word = model_mem[idx];
      if (wr) begin
        if (!e.err) begin
          for (int i = 0; i < n; i++) word[8*(off+i) +: 8] = d[8*i +: 8];
          model_mem[idx] = word;
        end
      end else if (e.err) begin
        e.result = 32'h0;
      end else if (n == 1) begin
        val = (word >> (8 * off)) & 32'hFF;
        if (!f3[2] && val[7]) val = val | 32'hFFFF_FF00;
        e.result = val;
      end else if (n == 2) begin
        val = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (!f3[2] && val[15]) val = val | 32'hFFFF_0000;
        e.result = val;
      end else begin
        e.result = word;
      end
    end
    if (v) res_q.push_back(e);
    me_valid      = v;
    me_mem_read   = rd;
    me_mem_write  = wr;
    me_func3_code = f3;
    me_alu_o      = a;
    me_regs_data2 = d;
    wait_advance();
  endtask

  task automatic reset_mid_req();
    bus_t b;
    int   c;
    b = '{we: 1'b0, addr: 32'h204, be: 4'hF, wdata: 32'h0, wait_n: NEVER};
    bus_q.push_back(b);
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0;
    me_func3_code = 3'd2; me_alu_o = 32'h204; me_regs_data2 = 32'h0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!dmem_req && c < 20);
    check("rst_req_seen", 32'(dmem_req), 32'd1);
    #2;
    aborted  = 1'b1;
    me_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    check("rst_req_drop", 32'(dmem_req), 32'd0);
    check("rst_stall_drop", 32'(mem_stall), 32'd0);
    check("rst_be_clear", 32'(dmem_be), 32'd0);
    check("rst_addr_clear", dmem_addr, 32'd0);
    @(negedge clk);
    #2;
    rstn    = 1'b1;
    aborted = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, r;
    logic [2:0]  f3;
    bit          v, rd, wr;
    int          w;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom;
      slave_mem[i] = model_mem[i];
    end
    model_mem[128] = 32'h80F0_7F01;
    slave_mem[128] = 32'h80F0_7F01;

    // Misaligned load held during reset: stall and misalign must stay gated.
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0;
    me_func3_code = 3'd2; me_alu_o = 32'h101; me_regs_data2 = 32'h0;
    #3;
    check("reset dmem_req", 32'(dmem_req), 32'd0);
    check("reset dmem_we", 32'(dmem_we), 32'd0);
    check("reset dmem_addr", dmem_addr, 32'd0);
    check("reset dmem_wdata", dmem_wdata, 32'd0);
    check("reset dmem_be", 32'(dmem_be), 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    check("reset misalign", 32'(misalign), 32'd0);
    check("reset mem_stall", 32'(mem_stall), 32'd0);
    me_valid = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    issue(1, 0, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, "sw_100");
    issue(1, 1, 0, 3'd0, 32'h203, 32'h0, 0, "lb_203");
    issue(1, 1, 0, 3'd4, 32'h203, 32'h0, 1, "lbu_203");
    issue(1, 1, 0, 3'd1, 32'h202, 32'h0, 2, "lh_202");
    issue(1, 1, 0, 3'd5, 32'h200, 32'h0, 3, "lhu_200");
    issue(1, 0, 1, 3'd0, 32'h102, 32'h0000_00AB, 0, "sb_102");
    issue(1, 0, 1, 3'd1, 32'h102, 32'h0000_1234, 1, "sh_102");
    issue(1, 1, 0, 3'd2, 32'h101, 32'h0, 0, "lw_mis_101");
    issue(1, 1, 0, 3'd2, 32'h100, 32'h0, 0, "lw_100");
    issue(1, 1, 0, 3'd2, 32'h208, 32'h0, NEVER, "lw_timeout");
    issue(1, 0, 1, 3'd2, 32'h20C, 32'h1111_2222, NEVER, "sw_timeout");
    issue(1, 0, 0, 3'd2, 32'h1234_5677, 32'h0, 0, "alu_op");
    reset_mid_req();
    issue(1, 1, 0, 3'd2, 32'h200, 32'h0, 0, "lw_after_rst");
    issue(1, 1, 1, 3'd2, 32'h210, 32'hCAFE_F00D, 1, "rdwr_as_sw");
    issue(1, 1, 0, 3'd2, 32'h210, 32'h0, 0, "lw_210");

    for (int t = 0; t < 200; t++) begin
      v  = ($urandom_range(0, 7) != 0);
      r  = $urandom_range(0, 3);
      rd = (r == 1) || (r == 3);
      wr = (r == 2) || (r == 3);
      f3 = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (rd || wr) begin
        a = 32'h200 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      end else begin
        a = $urandom;
      end
      w = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
      issue(v, rd, wr, f3, a, d, w, $sformatf("rnd%0d", t));
    end

    me_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
